// File: rtl/seg_pkg.sv
// Shared definitions for the result display: FSM encoding, segment codes,
// the decimal range limit and a digit-to-segment helper.
package seg_pkg;

   // Controller state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_CONV_X = 3'd2;
   localparam logic [2:0] ST_CONV_Y = 3'd3;
   localparam logic [2:0] ST_COMMIT = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      LOAD   = ST_LOAD,
      CONV_X = ST_CONV_X,
      CONV_Y = ST_CONV_Y,
      COMMIT = ST_COMMIT
   } state_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // Largest value that fits in four decimal digits
   localparam int unsigned BCD_LIMIT = 9999;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_result_display_bcd_dabble16.sv
// Sequential 16-bit binary to 4-digit BCD converter (double-dabble).
// A start pulse loads the operand; the next 16 cycles each perform one
// add-3/shift iteration. 'last' is high during the cycle whose edge
// finishes the conversion, 'done' is high the cycle after, when 'bcd'
// holds the result. A new start is accepted in the 'last' cycle, so two
// conversions can run back to back without a gap.
module bcd_dabble16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] data,
   output logic        last,
   output logic        done,
   output logic [15:0] bcd
);

   logic [15:0] bin_q;
   logic [15:0] work_q;
   logic [15:0] work_adj;
   logic [15:0] work_next;
   logic [15:0] bcd_q;
   logic [3:0]  cnt_q;
   logic        run_q;
   logic        done_q;

   // Add 3 to every nibble that is 5 or more, then shift in the next bit
   always_comb begin
      work_adj = work_q;
      for (int i = 0; i < 4; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
      work_next = {work_adj[14:0], bin_q[15]};
      last      = run_q && (cnt_q == 4'd15);
   end

   // Iteration registers; the finished value is parked in bcd_q so the
   // working registers can already take the next operand
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         work_q <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= last;
         if (last) bcd_q <= work_next;
         if (start) begin
            bin_q  <= data;
            work_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
         end else if (run_q) begin
            bin_q  <= {bin_q[14:0], 1'b0};
            work_q <= work_next;
            cnt_q  <= cnt_q + 4'd1;
            if (last) run_q <= 1'b0;
         end
      end
   end

   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_result_display.sv
// Captures the X/Y search results, converts each to four decimal digits
// and scans all eight digits onto an active-low 7-segment display.
// Handshake: Valid is a single-cycle strobe with no ready; a strobe while
// Busy is never lost but parked in a one-deep buffer where the newest
// strobe wins. Display registers only change in COMMIT, so a partially
// converted value never reaches the segments.
module seg_result_display
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] MinX,
   input  logic [DATA_W-1:0] MinY,
   input  logic              Valid,
   output logic              Busy,
   output logic [7:0]        Anode,
   output logic [6:0]        Segment,
   output logic              DP,
   output logic [2:0]        dbg_state
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   cap_x, cap_y;
   logic [DATA_W-1:0]   pend_x, pend_y;
   logic                pending_q;
   logic                ovf_x_q, ovf_y_q;
   logic [15:0]         res_x_q;
   logic [15:0]         disp_x, disp_y;
   logic                disp_ovf_x, disp_ovf_y;

   logic                eng_start;
   logic [15:0]         eng_data;
   logic                eng_last;
   logic                eng_done;
   logic [15:0]         eng_bcd;

   logic [CNT_W-1:0]    ref_q;
   logic [2:0]          idx_q, idx_d;
   logic                wrap;
   logic [3:0]          nib;
   logic                nib_ovf;
   logic [6:0]          seg_d;
   logic [7:0]          anode_q;
   logic [6:0]          seg_q;

   bcd_dabble16 u_dabble (
      .clk   (Clk),
      .reset (Reset),
      .start (eng_start),
      .data  (eng_data),
      .last  (eng_last),
      .done  (eng_done),
      .bcd   (eng_bcd)
   );

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and converter launch; X and Y share one engine, Y is
   // started in the same cycle X finishes
   always_comb begin
      state_d   = state_q;
      eng_start = 1'b0;
      eng_data  = cap_x[15:0];
      case (state_q)
         IDLE:   if (Valid) state_d = LOAD;
         LOAD: begin
            eng_start = 1'b1;
            eng_data  = cap_x[15:0];
            state_d   = CONV_X;
         end
         CONV_X: if (eng_last) begin
            eng_start = 1'b1;
            eng_data  = cap_y[15:0];
            state_d   = CONV_Y;
         end
         CONV_Y: if (eng_last) state_d = COMMIT;
         COMMIT: state_d = (Valid || pending_q) ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture, pending buffer, overflow flags and atomic display commit
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cap_x      <= '0;
         cap_y      <= '0;
         pend_x     <= '0;
         pend_y     <= '0;
         pending_q  <= 1'b0;
         ovf_x_q    <= 1'b0;
         ovf_y_q    <= 1'b0;
         res_x_q    <= '0;
         disp_x     <= '0;
         disp_y     <= '0;
         disp_ovf_x <= 1'b0;
         disp_ovf_y <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (Valid) begin
               cap_x <= MinX;
               cap_y <= MinY;
            end
            COMMIT: begin
               disp_x     <= res_x_q;
               disp_y     <= eng_bcd;
               disp_ovf_x <= ovf_x_q;
               disp_ovf_y <= ovf_y_q;
               // A strobe in this very cycle is newer than the buffer
               if (Valid) begin
                  cap_x     <= MinX;
                  cap_y     <= MinY;
                  pending_q <= 1'b0;
               end else if (pending_q) begin
                  cap_x     <= pend_x;
                  cap_y     <= pend_y;
                  pending_q <= 1'b0;
               end
            end
            default: if (Valid) begin
               pend_x    <= MinX;
               pend_y    <= MinY;
               pending_q <= 1'b1;
            end
         endcase
         if (state_q == LOAD) begin
            ovf_x_q <= (cap_x > DATA_W'(BCD_LIMIT));
            ovf_y_q <= (cap_y > DATA_W'(BCD_LIMIT));
         end
         // The X result is saved before the Y conversion overwrites it
         if (state_q == CONV_Y && eng_done) res_x_q <= eng_bcd;
      end
   end

   // Digit selection for the index that will be lit after this edge
   always_comb begin
      wrap  = (ref_q == CNT_W'(REFRESH_DIV - 1));
      idx_d = wrap ? idx_q + 3'd1 : idx_q;
      if (idx_d[2]) begin
         nib     = disp_x[{idx_d[1:0], 2'b00} +: 4];
         nib_ovf = disp_ovf_x;
      end else begin
         nib     = disp_y[{idx_d[1:0], 2'b00} +: 4];
         nib_ovf = disp_ovf_y;
      end
      seg_d = nib_ovf ? SEG_DASH : seg_encode(nib);
   end

   // Free-running refresh scan, independent of the controller
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ref_q   <= '0;
         idx_q   <= '0;
         anode_q <= 8'hFE;
         seg_q   <= SEG_0;
      end else begin
         ref_q   <= wrap ? '0 : ref_q + 1'b1;
         idx_q   <= idx_d;
         anode_q <= ~(8'd1 << idx_d);
         seg_q   <= seg_d;
      end
   end

   assign Busy      = (state_q != IDLE);
   assign Anode     = anode_q;
   assign Segment   = seg_q;
   assign DP        = 1'b1;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_result_display.sv
// Bench for seg_result_display with a short refresh period. Expected
// segment patterns come from a decimal model of the X/Y results.
module tb_seg_result_display;

   localparam int unsigned DIV = 4;
   localparam int unsigned DW  = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] min_x = '0;
   logic [DW-1:0] min_y = '0;
   logic          valid = 1'b0;
   logic          busy;
   logic [7:0]    anode;
   logic [6:0]    segment;
   logic          dp;
   logic [2:0]    dbg_state;

   int total = 0;
   int bad   = 0;

   seg_result_display #(.REFRESH_DIV(DIV), .DATA_W(DW)) dut (
      .Clk       (clk),
      .Reset     (reset),
      .MinX      (min_x),
      .MinY      (min_y),
      .Valid     (valid),
      .Busy      (busy),
      .Anode     (anode),
      .Segment   (segment),
      .DP        (dp),
      .dbg_state (dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Reference model: digit value -> segment code
   function automatic logic [6:0] code_of(input int d);
      logic [6:0] tab [10];
      tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tab[d];
   endfunction

   // Expected segments on digit i for results x/y
   function automatic logic [6:0] exp_seg(input longint unsigned x, input longint unsigned y, input int i);
      longint unsigned v;
      int pos;
      v   = (i >= 4) ? x : y;
      pos = (i >= 4) ? i - 4 : i;
      if (v > 9999) return 7'h3F;
      for (int k = 0; k < pos; k++) v = v / 10;
      return code_of(int'(v % 10));
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic pulse_valid(input logic [DW-1:0] x, input logic [DW-1:0] y);
      @(negedge clk);
      min_x = x;
      min_y = y;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   // Count cycles Busy stays high after a Valid pulse (bounded)
   task automatic count_busy(output int n);
      n = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
   endtask

   // Watch a full scan and compare each lit digit against the model
   task automatic check_display(input longint unsigned x, input longint unsigned y, input string name);
      int idx;
      for (int c = 0; c < 8 * DIV + 4; c++) begin
         @(negedge clk);
         idx = -1;
         for (int i = 0; i < 8; i++) if (anode === ~(8'd1 << i)) idx = i;
         total++;
         if (idx < 0) begin
            bad++;
            $display("FAIL %s anode: got %h, required one digit enabled", name, anode);
         end else if (segment !== exp_seg(x, y, idx)) begin
            bad++;
            $display("FAIL %s digit%0d: got %h, required %h", name, idx, segment, exp_seg(x, y, idx));
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || anode !== 8'hFE || segment !== 7'h40 || dp !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: got busy=%b anode=%h seg=%h dp=%b, required 0 fe 40 1",
                  busy, anode, segment, dp);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      check_display(0, 0, "reset_scan");
   endtask

   task automatic test_scan();
      logic [7:0] exp_an;
      apply_reset();
      for (int k = 0; k < 8 * DIV + 8; k++) begin
         @(negedge clk);
         exp_an = ~(8'd1 << ((k / DIV) % 8));
         total++;
         if (anode !== exp_an || segment !== 7'h40 || dp !== 1'b1) begin
            bad++;
            $display("FAIL scan k=%0d: got anode=%h seg=%h dp=%b, required %h 40 1",
                     k, anode, segment, dp, exp_an);
         end
      end
   endtask

   task automatic test_convert(input logic [DW-1:0] x, input logic [DW-1:0] y, input string name);
      int n;
      pulse_valid(x, y);
      count_busy(n);
      total++;
      if (n !== 34) begin
         bad++;
         $display("FAIL %s busy_len: got %0d, required 34", name, n);
      end
      check_display(x, y, name);
   endtask

   task automatic test_random();
      logic [DW-1:0] x, y;
      for (int t = 0; t < 6; t++) begin
         x = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 9999));
         y = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 9999));
         test_convert(x, y, "random");
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [6:0] seen [8];
      for (int i = 0; i < 8; i++) seen[i] = 7'h7F;
      pulse_valid(1, 2);
      n = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n >= 36 && n <= 67)
            for (int i = 0; i < 8; i++) if (anode === ~(8'd1 << i)) seen[i] = segment;
         valid = (n == 5 || n == 10);
         if (n == 5)  begin min_x = 3; min_y = 4; end
         if (n == 10) begin min_x = 7; min_y = 8; end
      end
      valid = 1'b0;
      total++;
      if (n !== 68) begin
         bad++;
         $display("FAIL b2b busy_len: got %0d, required 68", n);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (seen[i] !== exp_seg(1, 2, i)) begin
            bad++;
            $display("FAIL b2b first_commit digit%0d: got %h, required %h", i, seen[i], exp_seg(1, 2, i));
         end
      end
      check_display(7, 8, "b2b_final");
   endtask

   task automatic test_reset_mid();
      int n;
      int late_busy;
      pulse_valid(55, 66);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         valid = (c == 3);
         if (c == 3) begin min_x = 11; min_y = 22; end
         if (c == 25) reset = 1'b1;
      end
      valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (busy !== 1'b0 || anode !== 8'hFE || segment !== 7'h40) begin
         bad++;
         $display("FAIL reset_mid state: got busy=%b anode=%h seg=%h, required 0 fe 40",
                  busy, anode, segment);
      end
      late_busy = 0;
      for (n = 0; n < 80; n++) begin
         @(negedge clk);
         if (busy) late_busy++;
      end
      total++;
      if (late_busy !== 0) begin
         bad++;
         $display("FAIL reset_mid late_busy: got %0d cycles, required 0", late_busy);
      end
      check_display(0, 0, "reset_mid_display");
   endtask

   initial begin
      test_reset();
      test_scan();
      test_convert(12, 345, "basic");
      test_convert(10000, 9999, "overflow_x");
      test_convert(9999, 32'h0001_0005, "overflow_y");
      test_convert(0, 0, "zeros");
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
